// File: rtl/wb_commit_pkg.sv
// Shared register-file types and constants for the writeback commit slice.
package wb_commit_pkg;
  localparam int RegNum    = 32;
  localparam int RegAddrW  = 5;
  localparam int RegW      = 32;

  typedef logic [RegAddrW-1:0] RegAddrBus;
  typedef logic [RegW-1:0]     RegBus;

  localparam RegAddrBus NOPRegAddr   = '0;
  localparam RegBus     ZeroWord     = '0;
  localparam logic      WriteEnable  = 1'b1;
  localparam logic      WriteDisable = 1'b0;
  localparam logic      ReadEnable   = 1'b1;
  localparam logic      ReadDisable  = 1'b0;
endpackage

// File: rtl/wb_commit_regfile.sv
// General register file: one write port, NRP bypassed combinational read ports.
module wb_commit_regfile
  import wb_commit_pkg::*;
#(
  parameter int NREG = RegNum,
  parameter int DW   = RegW,
  parameter int AW   = $clog2(NREG),
  parameter int NRP  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [DW-1:0]           wdata,
  input  logic [NRP-1:0]          re,
  input  logic [NRP-1:0][AW-1:0]  raddr,
  output logic [NRP-1:0][DW-1:0]  rdata
);
  logic [DW-1:0] regs [NREG];
  logic          commit;

  // $0 is hardwired zero, so it is never stored; contents are not reset.
  assign commit = !rst && (we == WriteEnable) && (waddr != '0);

  always_ff @(posedge clk) begin
    if (commit) regs[waddr] <= wdata;
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    assign rdata[p] = (rst || raddr[p] == '0 || re[p] == ReadDisable) ? '0 :
                      (we == WriteEnable && waddr == raddr[p])        ? wdata :
                      regs[raddr[p]];
  end
endmodule

// File: rtl/wb_commit.sv
// Writeback commit: register file, HI/LO pair, LL/SC link bit and commit counter.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int NREG = RegNum,
  parameter int DW   = RegW,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] wb_wd,
  input  logic          wb_wreg,
  input  logic [DW-1:0] wb_wdata,
  input  logic          wb_whilo,
  input  logic [DW-1:0] wb_hi,
  input  logic [DW-1:0] wb_lo,
  input  logic          wb_LLbit_we,
  input  logic          wb_LLbit_value,
  input  logic          flush,
  input  logic          re1,
  input  logic          re2,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic          LLbit_o,
  output logic [DW-1:0] wr_count
);
  logic [1:0][DW-1:0] rdata;
  logic               llbit;

  wb_commit_regfile #(.NREG(NREG), .DW(DW), .AW(AW), .NRP(2)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_wreg),
    .waddr (wb_wd),
    .wdata (wb_wdata),
    .re    ({re2, re1}),
    .raddr ({raddr2, raddr1}),
    .rdata (rdata)
  );

  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (wb_whilo == WriteEnable) begin
      hi_o <= wb_hi;
      lo_o <= wb_lo;
    end
  end

  // flush outranks a same-cycle LL/SC update so a squashed SC cannot succeed.
  always_ff @(posedge clk) begin
    if (rst || flush)                     llbit <= 1'b0;
    else if (wb_LLbit_we == WriteEnable)  llbit <= wb_LLbit_value;
  end

  assign LLbit_o = flush       ? 1'b0 :
                   wb_LLbit_we ? wb_LLbit_value : llbit;

  always_ff @(posedge clk) begin
    if (rst)                                            wr_count <= '0;
    else if (wb_wreg == WriteEnable && wb_wd != '0)     wr_count <= wr_count + 1'b1;
  end
endmodule

// File: tb/tb_wb_commit.sv
// Directed and randomized checks of wb_commit against a behavioural model.
module tb_wb_commit;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi, wb_lo;
  logic        wb_LLbit_we, wb_LLbit_value, flush;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, hi_o, lo_o, wr_count;
  logic        LLbit_o;

  int total = 0;
  int bad   = 0;

  // Model state: architectural registers, which of them hold a defined value, and the rest.
  logic [31:0] m_reg [32];
  bit          m_vld [32];
  logic [31:0] m_hi, m_lo, m_cnt;
  bit          m_ll;

  always #5 clk = ~clk;

  wb_commit dut (
    .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_LLbit_we(wb_LLbit_we),
    .wb_LLbit_value(wb_LLbit_value), .flush(flush), .re1(re1), .re2(re2),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o), .LLbit_o(LLbit_o), .wr_count(wr_count)
  );

  task automatic idle();
    wb_wreg = 0; wb_wd = 0; wb_wdata = 0; wb_whilo = 0; wb_hi = 0; wb_lo = 0;
    wb_LLbit_we = 0; wb_LLbit_value = 0; flush = 0;
  endtask

  // Apply the commit rules to the model for the bundle now on the inputs, then clock.
  task automatic tick();
    if (rst) begin
      m_hi = 0; m_lo = 0; m_ll = 0; m_cnt = 0;
    end else begin
      if (wb_wreg && wb_wd != 0) begin
        m_reg[wb_wd] = wb_wdata; m_vld[wb_wd] = 1; m_cnt = m_cnt + 1;
      end
      if (wb_whilo) begin m_hi = wb_hi; m_lo = wb_lo; end
      if (flush) m_ll = 0;
      else if (wb_LLbit_we) m_ll = wb_LLbit_value;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a, output bit known);
    known = 1;
    if (rst || a == 0 || !re) return 32'h0;
    if (wb_wreg && wb_wd == a) return wb_wdata;
    known = m_vld[a];
    return m_reg[a];
  endfunction

  task automatic test_reset();
    rst = 1; idle();
    wb_wreg = 1; wb_wd = 3; wb_wdata = 32'hBAD0BAD3;
    wb_whilo = 1; wb_hi = 32'hFFFF; wb_lo = 32'hEEEE;
    re1 = 1; raddr1 = 3; re2 = 0; raddr2 = 0;
    #1;
    total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL reset_rdata1 got=%h want=0", rdata1); end
    tick(); tick();
    total++; if (hi_o !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi_o); end
    total++; if (lo_o !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo_o); end
    total++; if (LLbit_o !== 1'b0) begin bad++; $display("FAIL reset_llbit got=%b want=0", LLbit_o); end
    total++; if (wr_count !== 32'h0) begin bad++; $display("FAIL reset_count got=%h want=0", wr_count); end
    rst = 0; idle();
    tick();
    total++; if (rdata1 === 32'hBAD0BAD3) begin bad++; $display("FAIL reset_write_lost got=%h want=not BAD0BAD3", rdata1); end
    total++; if (wr_count !== 32'h0) begin bad++; $display("FAIL reset_count_after got=%h want=0", wr_count); end
  endtask

  task automatic test_write_bypass();
    idle();
    wb_wreg = 1; wb_wd = 5; wb_wdata = 32'hDEADBEEF; re1 = 1; raddr1 = 5;
    #1;
    total++; if (rdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass got=%h want=deadbeef", rdata1); end
    tick(); idle(); #1;
    total++; if (rdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL stored_read got=%h want=deadbeef", rdata1); end
    total++; if (wr_count !== 32'd1) begin bad++; $display("FAIL count_one got=%h want=1", wr_count); end
  endtask

  task automatic test_zero_and_re();
    idle();
    wb_wreg = 1; wb_wd = 0; wb_wdata = 32'h12345678; re1 = 1; raddr1 = 0;
    #1;
    total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL zero_bypass got=%h want=0", rdata1); end
    tick(); idle(); #1;
    total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL zero_read got=%h want=0", rdata1); end
    total++; if (wr_count !== m_cnt) begin bad++; $display("FAIL zero_count got=%h want=%h", wr_count, m_cnt); end
    re2 = 0; raddr2 = 5; #1;
    total++; if (rdata2 !== 32'h0) begin bad++; $display("FAIL re2_off got=%h want=0", rdata2); end
  endtask

  task automatic test_dual_read();
    idle(); re1 = 0; re2 = 0;
    wb_wreg = 1; wb_wd = 7; wb_wdata = 32'h11; tick();
    wb_wd = 8; wb_wdata = 32'h22; tick();
    idle(); re1 = 1; re2 = 1; raddr1 = 7; raddr2 = 8; #1;
    total++; if (rdata1 !== 32'h11) begin bad++; $display("FAIL dual_p1 got=%h want=11", rdata1); end
    total++; if (rdata2 !== 32'h22) begin bad++; $display("FAIL dual_p2 got=%h want=22", rdata2); end
    raddr2 = 7; #1;
    total++; if (rdata1 !== 32'h11) begin bad++; $display("FAIL same_p1 got=%h want=11", rdata1); end
    total++; if (rdata2 !== 32'h11) begin bad++; $display("FAIL same_p2 got=%h want=11", rdata2); end
  endtask

  task automatic test_hilo();
    idle(); wb_whilo = 1; wb_hi = 32'hA; wb_lo = 32'hB; #1;
    total++; if (hi_o !== 32'h0) begin bad++; $display("FAIL hi_before_edge got=%h want=0", hi_o); end
    tick();
    total++; if (hi_o !== 32'hA) begin bad++; $display("FAIL hi_write got=%h want=a", hi_o); end
    total++; if (lo_o !== 32'hB) begin bad++; $display("FAIL lo_write got=%h want=b", lo_o); end
    wb_whilo = 0; wb_hi = 32'h1; wb_lo = 32'h2; tick();
    total++; if (hi_o !== 32'hA) begin bad++; $display("FAIL hi_hold got=%h want=a", hi_o); end
    total++; if (lo_o !== 32'hB) begin bad++; $display("FAIL lo_hold got=%h want=b", lo_o); end
  endtask

  task automatic test_llbit();
    idle(); wb_LLbit_we = 1; wb_LLbit_value = 1; #1;
    total++; if (LLbit_o !== 1'b1) begin bad++; $display("FAIL ll_bypass got=%b want=1", LLbit_o); end
    tick(); idle(); #1;
    total++; if (LLbit_o !== 1'b1) begin bad++; $display("FAIL ll_stored got=%b want=1", LLbit_o); end
    flush = 1; wb_LLbit_we = 1; wb_LLbit_value = 1; #1;
    total++; if (LLbit_o !== 1'b0) begin bad++; $display("FAIL ll_flush_comb got=%b want=0", LLbit_o); end
    tick(); idle(); #1;
    total++; if (LLbit_o !== 1'b0) begin bad++; $display("FAIL ll_flush_stored got=%b want=0", LLbit_o); end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    bit k1, k2;
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 39) == 0);
      wb_wreg        = $urandom_range(0, 2) != 0;
      wb_wd          = 5'($urandom_range(0, 11));
      wb_wdata       = $urandom;
      wb_whilo       = $urandom_range(0, 1);
      wb_hi          = $urandom;
      wb_lo          = $urandom;
      wb_LLbit_we    = $urandom_range(0, 1);
      wb_LLbit_value = $urandom_range(0, 1);
      flush          = ($urandom_range(0, 5) == 0);
      re1            = $urandom_range(0, 5) != 0;
      re2            = $urandom_range(0, 5) != 0;
      raddr1         = 5'($urandom_range(0, 11));
      raddr2         = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 11));
      #1;
      e1 = exp_rd(re1, raddr1, k1);
      e2 = exp_rd(re2, raddr2, k2);
      if (k1) begin total++; if (rdata1 !== e1) begin bad++; $display("FAIL rnd_rdata1 i=%0d got=%h want=%h", i, rdata1, e1); end end
      if (k2) begin total++; if (rdata2 !== e2) begin bad++; $display("FAIL rnd_rdata2 i=%0d got=%h want=%h", i, rdata2, e2); end end
      total++;
      if (LLbit_o !== (flush ? 1'b0 : wb_LLbit_we ? wb_LLbit_value : m_ll)) begin
        bad++; $display("FAIL rnd_llbit i=%0d got=%b stored=%b", i, LLbit_o, m_ll);
      end
      tick();
      total++; if (hi_o !== m_hi) begin bad++; $display("FAIL rnd_hi i=%0d got=%h want=%h", i, hi_o, m_hi); end
      total++; if (lo_o !== m_lo) begin bad++; $display("FAIL rnd_lo i=%0d got=%h want=%h", i, lo_o, m_lo); end
      total++; if (wr_count !== m_cnt) begin bad++; $display("FAIL rnd_count i=%0d got=%h want=%h", i, wr_count, m_cnt); end
    end
    rst = 0; idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_vld[i] = 0; end
    m_hi = 0; m_lo = 0; m_cnt = 0; m_ll = 0;
    rst = 1; idle(); re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
    test_reset();
    test_write_bypass();
    test_zero_and_re();
    test_dual_read();
    test_hilo();
    test_llbit();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_commit.md
# wb_commit

Architectural-state commit block at the far end of the MEM/WB pipeline register. It consumes the writeback bundle emitted each cycle by MEM/WB and commits it into three stores:
- the 32x32 general register file,
- the HI/LO pair,
- the LL/SC link bit.

It serves the decode stage's two register read ports with same-cycle write bypass, and presents HI/LO and LLbit to the execute and memory stages.

## Interface
Parameters:
- NREG, 32, number of general registers (address width 5).
- DW, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wb_wd  in  5  destination register address.
- wb_wreg  in  1  register-file write enable.
- wb_wdata  in  32  register write data.
- wb_whilo  in  1  HI/LO write enable.
- wb_hi  in  32  HI write data.
- wb_lo  in  32  LO write data.
- wb_LLbit_we  in  1  link-bit write enable.
- wb_LLbit_value  in  1  link-bit write data.
- flush  in  1  exception flush; clears the link bit.
- re1, re2  in  1  read enables, decode ports 1/2.
- raddr1, raddr2  in  5  read addresses.
- rdata1, rdata2  out  32  read data (combinational).
- hi_o, lo_o  out  32  committed HI/LO (registered).
- LLbit_o  out  1  link bit, bypassed (combinational).
- wr_count  out  32  count of committed register-file writes.

## Operation
- Register-file write: at the posedge, when wb_wreg=1 and wb_wd!=0, reg[wb_wd] <= wb_wdata. Writes to $0 are dropped silently and are not counted.
- Register-file read, per port, in priority order:
  - rst=1 -> 0
  - raddr==0 -> 0
  - re=0 -> 0
  - wb_wreg=1 and wb_wd==raddr -> wb_wdata (bypass)
  - otherwise -> reg[raddr]
- Both ports may read the same address; each resolves independently.
- HI/LO: when wb_whilo=1, hi_o <= wb_hi and lo_o <= wb_lo at the posedge. No read bypass; the execute stage forwards from MEM and WB itself.
- LLbit register update, highest priority first:
  - flush=1 -> 0
  - wb_LLbit_we=1 -> wb_LLbit_value
  - otherwise hold
- LLbit_o is combinational, in this order:
  - flush -> 0
  - wb_LLbit_we -> wb_LLbit_value
  - otherwise the stored bit
- wr_count increments by 1 on every committed register-file write. It wraps from 0xFFFFFFFF to 0.
- Stall bubbles from MEM/WB arrive with all enables low, so they need no special handling and commit nothing.

## Timing
- Reset values:
  - hi_o=0, lo_o=0, LLbit=0 and wr_count=0.
  - rdata1/rdata2 read 0 while rst=1.
  - Register-file contents are not reset. Software must write a register before reading it.
- rst has priority over every write in the same cycle. A write presented during rst is lost, including the HI/LO, LLbit and counter updates.
- Write latency: one clock. The value is visible from storage in the cycle after the edge, and through the bypass in the same cycle.
- Read latency: zero (combinational).
- flush and wb_LLbit_we=1 in the same cycle: flush wins, the stored bit becomes 0, and LLbit_o=0 in that cycle.
- flush does not block register-file or HI/LO writes. MEM/WB has already squashed them.
- Reset released mid-stream: the first edge with rst=0 commits the bundle present at that edge.

## Structure
- The shared defines header holds:
  - RegAddrBus, RegBus, NOPRegAddr, ZeroWord
  - WriteEnable/WriteDisable, ReadEnable/ReadDisable
  - RegNum = 32.
- One natural sub-module, regfile: storage plus the two bypassed read ports.
- HI/LO, LLbit and wr_count stay in the top level.

## Test plan
- Reset: hold rst 2 cycles with wb_wreg=1, wb_wd=3 and wb_whilo=1 driven.
  - Required: hi_o=lo_o=0, LLbit_o=0, wr_count=0.
  - A later read of $3 shows no committed write and wr_count stays 0.
- Write/bypass: wb_wreg=1, wb_wd=5, wb_wdata=0xDEADBEEF, with re1=1, raddr1=5 in the same cycle.
  - Required: rdata1=0xDEADBEEF in that cycle, and again the next cycle from storage.
  - wr_count=1.
- $0 and read enable:
  - Write 0x12345678 to $0, then read $0 -> 0, and wr_count is unchanged.
  - Read $5 with re2=0 -> 0.
- Dual read: write $7=0x11 then $8=0x22, then read ports 1 and 2 at 7 and 8 -> 0x11 and 0x22. Read both ports at 7 -> 0x11 on each.
- HI/LO: wb_whilo=1, wb_hi=0xA, wb_lo=0xB.
  - Required: hi_o/lo_o change only after the edge, to 0xA/0xB.
  - With wb_whilo=0 and new data driven, the values hold.
- LLbit:
  - wb_LLbit_we=1, value=1 -> LLbit_o=1 immediately and after the edge.
  - Then flush=1 together with we=1, value=1 -> LLbit_o=0, and stored 0 after the edge.
